// File: rtl/fix2half_pipe.sv
// fix2half_pipe: three-stage, flow-controlled signed fixed-point to binary16
// converter with round-to-nearest-even, gradual underflow and saturation.
module fix2half_pipe #(
  parameter int FIXEDSIZE    = 32,
  parameter int RADIX        = 20,
  parameter int FLOATSIZE    = 16,
  parameter int EXPONENTBITS = 5,
  parameter int MANTISSABITS = 10
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FIXEDSIZE-1:0] in_fixed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOATSIZE-1:0] out_float,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  localparam int N     = FIXEDSIZE + 1;               // magnitude width, holds 2^(FIXEDSIZE-1)
  localparam int M     = MANTISSABITS;
  localparam int BIAS  = 2**(EXPONENTBITS-1) - 1;
  localparam int EMIN  = 1 - BIAS;                    // smallest normal unbiased exponent
  localparam int EMAXF = 2**EXPONENTBITS - 2;         // largest finite biased exponent
  localparam int EW    = 16;                          // signed exponent register width

  // Stage 1: sign / magnitude
  logic                 v1_q, s1_q, z1_q;
  logic [N-1:0]         mag1_q, mag1_d;
  logic [N-1:0]         ext;
  logic                 z1_d;

  // Stage 2: normalized magnitude and unbiased exponent
  logic                 v2_q, s2_q, z2_q;
  logic [N-1:0]         norm2_q, norm2_d;
  logic signed [EW-1:0] exp2_q, exp2_d;
  int                   p;

  // Stage 3: rounded and packed result
  logic                 v3_q;
  logic [FLOATSIZE-1:0] float3_q, float3_d;
  logic                 ovf3_q, ovf3_d, unf3_q, unf3_d;
  int                   e3, sh, bexp;
  logic [2*N-1:0]       wide;
  logic [M:0]           kept;
  logic                 guard, sticky, inc, sat;
  logic [M+1:0]         rnd;

  logic                 advance;

  assign advance       = out_ready | ~out_valid;
  assign in_ready      = advance;
  assign out_valid     = v3_q;
  assign out_float     = float3_q;
  assign out_overflow  = ovf3_q;
  assign out_underflow = unf3_q;

  // Stage 1 datapath: magnitude on one extra bit so the most negative input does not wrap
  always_comb begin
    ext    = {in_fixed[FIXEDSIZE-1], in_fixed};
    mag1_d = ext[N-1] ? (~ext + N'(1)) : ext;
    z1_d   = (in_fixed == '0);
  end

  // Stage 2 datapath: leading-one search, left-justify the magnitude
  always_comb begin
    p = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mag1_q[i]) p = int'(i);
    end
    norm2_d = mag1_q << (N - 1 - p);
    exp2_d  = EW'(p - RADIX);
  end

  // Stage 3 datapath: denormalizing shift, RNE rounding, pack and saturate.
  // Subnormals reuse the normal rounding path by pre-shifting the justified
  // value right; the trailing zero half of 'wide' keeps every shifted-out bit
  // available for the sticky OR, and shifts beyond N all round to zero anyway.
  always_comb begin
    e3 = int'(exp2_q);
    sh = (e3 < EMIN) ? (EMIN - e3) : 0;
    if (sh > N) sh = N;
    wide   = {norm2_q, {N{1'b0}}} >> sh;
    kept   = wide[2*N-1 -: M+1];
    guard  = wide[2*N-2-M];
    sticky = |wide[2*N-3-M:0];
    inc    = guard & (sticky | kept[0]);
    rnd    = {1'b0, kept} + {{(M+1){1'b0}}, inc};
    if (e3 < EMIN) bexp = int'(rnd[M]);
    else           bexp = e3 + BIAS + int'(rnd[M+1]);
    sat    = (bexp > EMAXF);
    if (z2_q) begin
      float3_d = '0;
      ovf3_d   = 1'b0;
      unf3_d   = 1'b0;
    end else if (sat) begin
      float3_d = {s2_q, EXPONENTBITS'(EMAXF), {M{1'b1}}};
      ovf3_d   = 1'b1;
      unf3_d   = 1'b0;
    end else begin
      float3_d = {s2_q, EXPONENTBITS'(bexp), rnd[M-1:0]};
      ovf3_d   = 1'b0;
      unf3_d   = (bexp == 0);
    end
  end

  // Pipeline registers: all stages advance together, everything holds on stall
  always_ff @(posedge clk) begin
    if (areset) begin
      v1_q     <= 1'b0;
      s1_q     <= 1'b0;
      z1_q     <= 1'b0;
      mag1_q   <= '0;
      v2_q     <= 1'b0;
      s2_q     <= 1'b0;
      z2_q     <= 1'b0;
      norm2_q  <= '0;
      exp2_q   <= '0;
      v3_q     <= 1'b0;
      float3_q <= '0;
      ovf3_q   <= 1'b0;
      unf3_q   <= 1'b0;
    end else if (advance) begin
      v1_q     <= in_valid;
      s1_q     <= in_fixed[FIXEDSIZE-1];
      z1_q     <= z1_d;
      mag1_q   <= mag1_d;
      v2_q     <= v1_q;
      s2_q     <= s1_q;
      z2_q     <= z1_q;
      norm2_q  <= norm2_d;
      exp2_q   <= exp2_d;
      v3_q     <= v2_q;
      float3_q <= float3_d;
      ovf3_q   <= ovf3_d;
      unf3_q   <= unf3_d;
    end
  end

endmodule
